// File: rtl/sram_arb_pkg.sv
// Shared types and default sizes for the SRAM port arbiter.
package sram_arb_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } arb_state_e;

    localparam int DEF_ADDR_W     = 10;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_NUM_PORTS  = 2;
    localparam int DEF_INIT_WORDS = 1024;

    // Width of a port-index register; a single port still needs one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first requester at or after rr wins.
module rr_arbiter #(
    parameter int N    = 2,
    parameter int RR_W = 1
) (
    input  logic [N-1:0]    req,
    input  logic [RR_W-1:0] rr,
    output logic [N-1:0]    gnt
);

    // walk the ports in rotated order and keep the first one found
    always_comb begin
        logic found;
        int   idx;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx      = (int'(rr) + i >= N) ? int'(rr) + i - N : int'(rr) + i;
            gnt[idx] = ~found & req[idx];
            found    = found | req[idx];
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Multi-port SRAM arbiter with optional init sequencer (macro SRAM_ARB_INIT_EN).
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int NUM_PORTS  = DEF_NUM_PORTS,
    parameter int INIT_WORDS = DEF_INIT_WORDS
) (
    input  logic                             Clk,
    input  logic                             Reset,
    input  logic [NUM_PORTS-1:0]             req,
    input  logic [NUM_PORTS-1:0]             we,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0] addr,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0] wdata,
    output logic [NUM_PORTS-1:0]             gnt,
    output logic [NUM_PORTS-1:0]             rvalid,
    output logic [DATA_W-1:0]                rdata,
    output logic [ADDR_W-1:0]                init_addr,
    input  logic [DATA_W-1:0]                init_data,
    output logic                             init_done,
    output logic [ADDR_W-1:0]                mem_address,
    output logic [DATA_W-1:0]                mem_data,
    output logic                             mem_wren,
    output logic                             mem_rden,
    input  logic [DATA_W-1:0]                mem_q
);

    localparam int RR_W = ptr_width(NUM_PORTS);

`ifdef SRAM_ARB_INIT_EN
    localparam arb_state_e RESET_STATE = INIT;
`else
    localparam arb_state_e RESET_STATE = RUN;
`endif

    arb_state_e           r_state;
    arb_state_e           w_next_state;
    logic [RR_W-1:0]      r_rr;
    logic [RR_W-1:0]      w_rr_next;
    logic [NUM_PORTS-1:0] r_rvalid;
    logic [NUM_PORTS-1:0] w_arb_gnt;
    logic [NUM_PORTS-1:0] w_gnt;
    logic                 r_init_done;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [DATA_W-1:0]    w_sel_data;
    logic                 w_sel_we;
    logic                 w_any_gnt;

    rr_arbiter #(
        .N    (NUM_PORTS),
        .RR_W (RR_W)
    ) u_rr_arbiter (
        .req (req),
        .rr  (r_rr),
        .gnt (w_arb_gnt)
    );

    assign w_gnt     = (r_state == RUN) ? w_arb_gnt : '0;
    assign w_any_gnt = |w_gnt;
    assign gnt       = w_gnt;
    assign rvalid    = r_rvalid;
    assign rdata     = mem_q;
    assign init_done = r_init_done;

    // one-hot grant drives an AND-OR mux of the port fields and the next pointer
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        w_sel_we   = 1'b0;
        w_rr_next  = r_rr;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_sel_addr = w_sel_addr | (addr[p] & {ADDR_W{w_gnt[p]}});
            w_sel_data = w_sel_data | (wdata[p] & {DATA_W{w_gnt[p]}});
            w_sel_we   = w_sel_we | (we[p] & w_gnt[p]);
            w_rr_next  = w_gnt[p] ? RR_W'((p + 1) % NUM_PORTS) : w_rr_next;
        end
    end

`ifdef SRAM_ARB_INIT_EN
    logic [ADDR_W-1:0] r_cnt;
    logic              w_cnt_last;

    assign w_cnt_last = (r_cnt == ADDR_W'(INIT_WORDS - 1));
    assign init_addr  = r_cnt;

    // init counter stops at the last word so it never wraps
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_cnt       <= '0;
            r_init_done <= 1'b0;
        end else if (r_state == INIT) begin
            r_cnt       <= w_cnt_last ? r_cnt : r_cnt + ADDR_W'(1);
            r_init_done <= w_cnt_last;
        end else begin
            r_cnt       <= r_cnt;
            r_init_done <= 1'b1;
        end
    end
`else
    logic w_unused_init;

    assign init_addr     = '0;
    assign w_unused_init = ^init_data;

    // without the init table the memory is usable right after reset
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_init_done <= 1'b0;
        end else begin
            r_init_done <= 1'b1;
        end
    end
`endif

    // next state and RAM command
    always_comb begin
        w_next_state = r_state;
        mem_address  = '0;
        mem_data     = '0;
        mem_wren     = 1'b0;
        mem_rden     = 1'b0;
        case (r_state)
            INIT: begin
`ifdef SRAM_ARB_INIT_EN
                mem_wren     = 1'b1;
                mem_address  = r_cnt;
                mem_data     = init_data;
                w_next_state = w_cnt_last ? RUN : INIT;
`else
                w_next_state = RUN;
`endif
            end
            RUN: begin
                mem_address = w_sel_addr;
                mem_data    = w_sel_data;
                mem_wren    = w_any_gnt & w_sel_we;
                mem_rden    = w_any_gnt & ~w_sel_we;
            end
            default: begin
                w_next_state = INIT;
            end
        endcase
    end

    // state, pointer and read-valid pipeline
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= RESET_STATE;
            r_rr     <= '0;
            r_rvalid <= '0;
        end else begin
            r_state  <= w_next_state;
            r_rr     <= w_rr_next;
            r_rvalid <= w_gnt & ~we;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter; covers both SRAM_ARB_INIT_EN builds.
module tb_sram_port_arbiter;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int NP = 2;
    localparam int IW = 4;

    logic                     Clk = 1'b0;
    logic                     Reset = 1'b1;
    logic [NP-1:0]            req;
    logic [NP-1:0]            we;
    logic [NP-1:0][AW-1:0]    addr;
    logic [NP-1:0][DW-1:0]    wdata;
    logic [NP-1:0]            gnt;
    logic [NP-1:0]            rvalid;
    logic [DW-1:0]            rdata;
    logic [AW-1:0]            init_addr;
    logic [DW-1:0]            init_data;
    logic                     init_done;
    logic [AW-1:0]            mem_address;
    logic [DW-1:0]            mem_data;
    logic                     mem_wren;
    logic                     mem_rden;
    logic [DW-1:0]            mem_q;
    logic [DW-1:0]            ram [0:(1<<AW)-1];

    int n_checks = 0;
    int n_errors = 0;

    sram_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .NUM_PORTS  (NP),
        .INIT_WORDS (IW)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .gnt         (gnt),
        .rvalid      (rvalid),
        .rdata       (rdata),
        .init_addr   (init_addr),
        .init_data   (init_data),
        .init_done   (init_done),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .mem_rden    (mem_rden),
        .mem_q       (mem_q)
    );

    always #5 Clk = ~Clk;

    assign init_data = 32'h0000_0100 + {28'h0, init_addr};

    always @(posedge Clk) begin
        if (mem_wren) ram[mem_address] <= mem_data;
        if (mem_rden) mem_q <= ram[mem_address];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        req      = 2'b01;
        we       = 2'b00;
        addr[0]  = 4'd2;
        addr[1]  = 4'd0;
        wdata[0] = 32'h0;
        wdata[1] = 32'h0;
        #1;
        check("rst_init_done", init_done, 1'b0);
        check("rst_rvalid", rvalid, 2'b00);
`ifdef SRAM_ARB_INIT_EN
        check("rst_gnt_init", gnt, 2'b00);
        check("rst_init_addr", init_addr, 4'd0);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                @(negedge Clk);
                #1;
            end
            check("init1_addr", mem_address, k);
            check("init1_wren", mem_wren, 1'b1);
            check("init1_gnt", gnt, 2'b00);
        end
        Reset = 1'b1;
        #1;
        check("midrst_init_addr", init_addr, 4'd0);
        check("midrst_done", init_done, 1'b0);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(negedge Clk);
                #1;
            end
            check("init_addr", init_addr, k);
            check("init_mem_addr", mem_address, k);
            check("init_mem_data", mem_data, 32'h100 + k);
            check("init_wren", mem_wren, 1'b1);
            check("init_gnt", gnt, 2'b00);
            check("init_done_low", init_done, 1'b0);
        end
        @(negedge Clk);
        #1;
        check("init_done_rise", init_done, 1'b1);
        check("first_gnt", gnt, 2'b01);
        check("first_rden", mem_rden, 1'b1);
        check("first_wren", mem_wren, 1'b0);
        check("first_addr", mem_address, 4'd2);
`else
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        check("noinit_gnt", gnt, 2'b01);
        check("noinit_rden", mem_rden, 1'b1);
        check("noinit_wren", mem_wren, 1'b0);
        check("noinit_addr", mem_address, 4'd2);
        check("noinit_done_low", init_done, 1'b0);
        check("noinit_init_addr", init_addr, 4'd0);
`endif
        // both ports write continuously; pointer now at port 1
        @(negedge Clk);
        req      = 2'b11;
        we       = 2'b11;
        addr[0]  = 4'd5;
        wdata[0] = 32'hDEAD_BEEF;
        addr[1]  = 4'd6;
        wdata[1] = 32'h1234_5678;
        #1;
        check("rd0_rvalid", rvalid, 2'b01);
`ifdef SRAM_ARB_INIT_EN
        check("rd0_rdata", rdata, 32'h0000_0102);
`else
        check("done_after_1", init_done, 1'b1);
`endif
        check("rr_gnt0", gnt, 2'b10);
        check("wr1_addr", mem_address, 4'd6);
        check("wr1_data", mem_data, 32'h1234_5678);
        check("wr1_wren", mem_wren, 1'b1);
        check("wr1_rden", mem_rden, 1'b0);
        for (int i = 1; i < 4; i++) begin
            @(negedge Clk);
            #1;
            check("rr_gnt", gnt, (i % 2 == 1) ? 2'b01 : 2'b10);
            check("wr_no_rvalid", rvalid, 2'b00);
            if (i == 1) begin
                check("wr0_addr", mem_address, 4'd5);
                check("wr0_data", mem_data, 32'hDEAD_BEEF);
            end
        end
        @(negedge Clk);
        req     = 2'b10;
        we      = 2'b00;
        addr[1] = 4'd5;
        #1;
        check("rd1_gnt", gnt, 2'b10);
        check("rd1_rden", mem_rden, 1'b1);
        check("rd1_wren", mem_wren, 1'b0);
        check("rd1_addr", mem_address, 4'd5);
        @(negedge Clk);
        req = 2'b00;
        #1;
        check("rd1_rvalid", rvalid, 2'b10);
        check("rd1_rdata", rdata, 32'hDEAD_BEEF);
        check("idle_gnt", gnt, 2'b00);
        check("idle_wren", mem_wren, 1'b0);
        check("idle_rden", mem_rden, 1'b0);
        // single requester, back-to-back reads
        @(negedge Clk);
        req     = 2'b10;
        addr[1] = 4'd6;
        #1;
        check("b2b_gnt0", gnt, 2'b10);
        check("b2b_rvalid0", rvalid, 2'b00);
        @(negedge Clk);
        addr[1] = 4'd5;
        #1;
        check("b2b_gnt1", gnt, 2'b10);
        check("b2b_rvalid1", rvalid, 2'b10);
        check("b2b_rdata1", rdata, 32'h1234_5678);
        @(negedge Clk);
        req = 2'b00;
        #1;
        check("b2b_rvalid2", rvalid, 2'b10);
        check("b2b_rdata2", rdata, 32'hDEAD_BEEF);
        @(negedge Clk);
        #1;
        check("b2b_rvalid3", rvalid, 2'b00);
        // read accepted just before reset must not report data
        @(negedge Clk);
        req     = 2'b01;
        addr[0] = 4'd5;
        #1;
        check("prerst_gnt", gnt, 2'b01);
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        req   = 2'b00;
        #1;
        check("rst_kill_rvalid", rvalid, 2'b00);
        check("rst_kill_done", init_done, 1'b0);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        check("postrst_rvalid", rvalid, 2'b00);
        @(negedge Clk);
        #1;
        check("postrst_rvalid2", rvalid, 2'b00);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
